alarm_controller: RTL and testbench

Keypad-driven arm/disarm controller forming the upstream end of the `flag` interface of the security sensor blocks. Consumes `firealarm`, `dooralarm` and `windowalarm` from the fire/door/window sensor modules and generates their `flag` suppression input. Also implements entry/exit delays, the siren timer, per-source alarm latches and wrong-code lockout. Sits beside `security`. Its `flag` output drives the door and window modules; the fire module's `flag` is tied to 0 so fire is never suppressed.

---
 rtl/alarm_controller.sv | 150 +++++++++++++++
 tb/tb_alarm_controller.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Keypad arm/disarm controller: code entry with lockout, entry/exit delays,
// siren timer and sticky per-source alarm latches feeding the sensor `flag`.
module alarm_controller #(
  parameter logic [15:0] CODE           = 16'h1234,
  parameter logic [15:0] EXIT_CYCLES    = 16'd100,
  parameter logic [15:0] ENTRY_CYCLES   = 16'd100,
  parameter logic [15:0] SIREN_CYCLES   = 16'd500,
  parameter int          MAX_TRIES      = 3,
  parameter logic [15:0] LOCKOUT_CYCLES = 16'd1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       firealarm,
  input  logic       dooralarm,
  input  logic       windowalarm,
  input  logic [3:0] key,
  input  logic       key_valid,
  output logic       flag,
  output logic       armed,
  output logic       siren,
  output logic [2:0] alarm_latched,
  output logic       lockout,
  output logic       code_ok,
  output logic       code_bad,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  localparam logic [2:0] LAST_TRY = 3'(MAX_TRIES - 1);

  state_t      st, st_nxt;
  logic [15:0] timer, timer_nxt;
  logic [2:0]  latch, latch_nxt;
  logic [15:0] code_buf;
  logic [2:0]  dig_cnt;
  logic [2:0]  fail_cnt;
  logic [15:0] lock_timer;
  logic        cmp_cyc, timer_done;

  assign cmp_cyc    = (dig_cnt == 3'd4);
  assign timer_done = (timer <= 16'd1);

  // Keypad: digit buffer, compare cycle, fail counter and lockout timer.
  always_ff @(posedge clock) begin
    if (reset) begin
      code_buf   <= '0;
      dig_cnt    <= '0;
      fail_cnt   <= '0;
      lockout    <= 1'b0;
      lock_timer <= '0;
    end else begin
      if (cmp_cyc)
        dig_cnt <= '0;
      else if (key_valid && !lockout) begin
        if (key <= 4'd9) begin
          code_buf <= {code_buf[11:0], key};
          dig_cnt  <= dig_cnt + 3'd1;
        end else if (key == 4'hC)
          dig_cnt <= '0;
      end

      if (lockout) begin
        if (lock_timer <= 16'd1) begin
          lockout  <= 1'b0;
          fail_cnt <= '0;
        end else
          lock_timer <= lock_timer - 16'd1;
      end else if (code_bad) begin
        fail_cnt <= fail_cnt + 3'd1;
        if (fail_cnt == LAST_TRY) begin
          lockout    <= 1'b1;
          lock_timer <= LOCKOUT_CYCLES;
        end
      end else if (code_ok)
        fail_cnt <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st    <= S_DISARMED;
      timer <= '0;
      latch <= '0;
    end else begin
      st    <= st_nxt;
      timer <= timer_nxt;
      latch <= latch_nxt;
    end
  end

  // Accept has priority over every sensor event in the same cycle.
  always_comb begin
    st_nxt    = st;
    timer_nxt = (timer != 16'd0) ? timer - 16'd1 : 16'd0;
    latch_nxt = latch | {firealarm, 2'b00};
    if (code_ok) begin
      latch_nxt = {firealarm, 2'b00};
      if (st == S_DISARMED) begin
        st_nxt    = S_EXIT;
        timer_nxt = EXIT_CYCLES;
      end else
        st_nxt = S_DISARMED;
    end else begin
      case (st)
        S_DISARMED: ;
        S_EXIT: if (timer_done) st_nxt = S_ARMED;
        S_ARMED: begin
          latch_nxt[1:0] = latch[1:0] | {windowalarm, dooralarm};
          if (windowalarm) begin
            st_nxt    = S_ALARM;
            timer_nxt = SIREN_CYCLES;
          end else if (dooralarm) begin
            st_nxt    = S_ENTRY;
            timer_nxt = ENTRY_CYCLES;
          end
        end
        S_ENTRY: begin
          latch_nxt[1] = latch[1] | windowalarm;
          if (windowalarm || timer_done) begin
            st_nxt    = S_ALARM;
            timer_nxt = SIREN_CYCLES;
          end
        end
        S_ALARM: begin
          latch_nxt[1:0] = latch[1:0] | {windowalarm, dooralarm};
          if (timer_done) st_nxt = S_ARMED;
        end
        default: st_nxt = S_DISARMED;
      endcase
    end
  end

  always_comb begin
    state         = st;
    flag          = (st == S_DISARMED) || (st == S_EXIT);
    armed         = (st != S_DISARMED);
    siren         = (st == S_ALARM) || latch[2];
    alarm_latched = latch;
    code_ok       = cmp_cyc && (code_buf == CODE);
    code_bad      = cmp_cyc && (code_buf != CODE);
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: vector table, directed scenarios and random
// stimulus checked every cycle against a deadline-based reference model.
module tb_alarm_controller;
  localparam logic [15:0] CODE  = 16'h1234;
  localparam longint      EXITC = 100, ENTRYC = 100, SIRENC = 500, LOCKC = 1000;
  localparam int          MAXT  = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1, firealarm = 1'b0, dooralarm = 1'b0, windowalarm = 1'b0;
  logic [3:0] key = 4'd0;
  logic       key_valid = 1'b0;
  logic       flag, armed, siren, lockout, code_ok, code_bad;
  logic [2:0] alarm_latched, state;

  alarm_controller dut (
    .clock(clock), .reset(reset), .firealarm(firealarm), .dooralarm(dooralarm),
    .windowalarm(windowalarm), .key(key), .key_valid(key_valid), .flag(flag),
    .armed(armed), .siren(siren), .alarm_latched(alarm_latched), .lockout(lockout),
    .code_ok(code_ok), .code_bad(code_bad), .state(state)
  );

  always #5 clock = ~clock;

  int n_checks = 0, n_fail = 0;

  // Reference model: timers are absolute deadlines (edge numbers), keys a queue.
  longint ecount = 0;
  int     m_st = 0;
  longint m_dl = 0, m_lock_drop = 0;
  int     m_dig[$];
  bit     m_pend = 0, m_lock = 0;
  int     m_fails = 0;
  bit [2:0] m_lat = 0;

  function automatic longint dly(longint v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic bit m_match();
    int val = 0;
    if (m_dig.size() != 4) return 1'b0;
    foreach (m_dig[i]) val = val * 16 + m_dig[i];
    return val == int'(CODE);
  endfunction

  task automatic model_step();
    bit acc, bad, tmo;
    ecount++;
    if (reset) begin
      m_st = 0; m_dl = 0; m_dig.delete(); m_pend = 0; m_fails = 0; m_lock = 0; m_lat = 0;
      return;
    end
    acc = m_pend && m_match();
    bad = m_pend && !acc;
    tmo = (ecount == m_dl);
    if (m_pend) begin
      m_pend = 0; m_dig.delete();
    end else if (key_valid && !m_lock) begin
      if (key <= 4'd9) begin
        m_dig.push_back(int'(key));
        if (m_dig.size() == 4) m_pend = 1;
      end else if (key == 4'hC) m_dig.delete();
    end
    if (m_lock) begin
      if (ecount == m_lock_drop) begin m_lock = 0; m_fails = 0; end
    end else if (bad) begin
      m_fails++;
      if (m_fails == MAXT) begin m_lock = 1; m_lock_drop = ecount + dly(LOCKC); end
    end else if (acc) m_fails = 0;
    if (acc) begin
      m_lat = {firealarm, 2'b00};
      if (m_st == 0) begin m_st = 1; m_dl = ecount + dly(EXITC); end
      else m_st = 0;
    end else begin
      m_lat[2] = m_lat[2] | firealarm;
      case (m_st)
        1: if (tmo) m_st = 2;
        2: begin
          m_lat[1:0] = m_lat[1:0] | {windowalarm, dooralarm};
          if (windowalarm) begin m_st = 4; m_dl = ecount + dly(SIRENC); end
          else if (dooralarm) begin m_st = 3; m_dl = ecount + dly(ENTRYC); end
        end
        3: if (windowalarm || tmo) begin
          if (windowalarm) m_lat[1] = 1'b1;
          m_st = 4; m_dl = ecount + dly(SIRENC);
        end
        4: begin
          m_lat[1:0] = m_lat[1:0] | {windowalarm, dooralarm};
          if (tmo) m_st = 2;
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [11:0] model_vec();
    bit ok = m_pend && m_match();
    return {3'(m_st), m_st < 2, m_st != 0, (m_st == 4) || m_lat[2], m_lat, m_lock,
            ok, m_pend && !ok};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {state, flag, armed, siren, alarm_latched, lockout, code_ok, code_bad};
  endfunction

  task automatic check(string name, logic [11:0] got, logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %03h, required %03h", name, ecount, got, exp);
    end
  endtask

  task automatic check1(string name, logic got, logic exp);
    check(name, {11'd0, got}, {11'd0, exp});
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(logic [3:0] k);
    key_valid = 1'b1; key = k;
    tick();
    key_valid = 1'b0;
  endtask

  // Leaves the bench in the compare cycle (code_ok/code_bad visible).
  task automatic enter(logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[4*i +: 4]);
  endtask

  typedef struct {
    bit rst, fire, door, win, kv;
    logic [3:0] k;
    logic [11:0] exp;
  } vec_t;

  function automatic vec_t v(bit rst, bit kv, logic [3:0] k, bit fire,
                             logic [2:0] st, bit fl, bit ar, bit si, logic [2:0] lat,
                             bit lk, bit ok, bit bad);
    vec_t r;
    r.rst = rst; r.fire = fire; r.door = 1'b0; r.win = 1'b0; r.kv = kv; r.k = k;
    r.exp = {st, fl, ar, si, lat, lk, ok, bad};
    return r;
  endfunction

  vec_t tbl[18];
  int   ok_cnt;
  int   fire_hold;
  logic [3:0] script[$];

  initial begin
    //            rst kv key  fire  st fl ar si lat    lk ok bad
    tbl[0]  = v(1, 0, 4'h0, 0, 0, 1, 0, 0, 3'b000, 0, 0, 0);
    tbl[1]  = v(0, 1, 4'h1, 0, 0, 1, 0, 0, 3'b000, 0, 0, 0);
    tbl[2]  = v(0, 1, 4'h2, 0, 0, 1, 0, 0, 3'b000, 0, 0, 0);
    tbl[3]  = v(0, 1, 4'hC, 0, 0, 1, 0, 0, 3'b000, 0, 0, 0);
    tbl[4]  = v(0, 1, 4'h1, 0, 0, 1, 0, 0, 3'b000, 0, 0, 0);
    tbl[5]  = v(0, 1, 4'h2, 0, 0, 1, 0, 0, 3'b000, 0, 0, 0);
    tbl[6]  = v(0, 1, 4'h3, 0, 0, 1, 0, 0, 3'b000, 0, 0, 0);
    tbl[7]  = v(0, 1, 4'hA, 0, 0, 1, 0, 0, 3'b000, 0, 0, 0);
    tbl[8]  = v(0, 1, 4'h4, 0, 0, 1, 0, 0, 3'b000, 0, 1, 0);
    tbl[9]  = v(0, 1, 4'h5, 0, 1, 1, 1, 0, 3'b000, 0, 0, 0);
    tbl[10] = v(0, 1, 4'h9, 0, 1, 1, 1, 0, 3'b000, 0, 0, 0);
    tbl[11] = v(0, 1, 4'h9, 0, 1, 1, 1, 0, 3'b000, 0, 0, 0);
    tbl[12] = v(0, 1, 4'h9, 0, 1, 1, 1, 0, 3'b000, 0, 0, 0);
    tbl[13] = v(0, 1, 4'h9, 0, 1, 1, 1, 0, 3'b000, 0, 0, 1);
    tbl[14] = v(0, 0, 4'h0, 1, 1, 1, 1, 1, 3'b100, 0, 0, 0);
    tbl[15] = v(0, 0, 4'h0, 0, 1, 1, 1, 1, 3'b100, 0, 0, 0);
    tbl[16] = v(1, 0, 4'h0, 0, 0, 1, 0, 0, 3'b000, 0, 0, 0);
    tbl[17] = v(0, 1, 4'h5, 0, 0, 1, 0, 0, 3'b000, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      reset = tbl[i].rst; firealarm = tbl[i].fire; dooralarm = tbl[i].door;
      windowalarm = tbl[i].win; key_valid = tbl[i].kv; key = tbl[i].k;
      tick();
      check($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
    end
    reset = 1'b0; key_valid = 1'b0; firealarm = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;

    // Arm, exit delay exactly EXITC cycles, window intrusion.
    enter(CODE);
    check1("t1_code_ok", code_ok, 1'b1);
    tick();
    check("t1_exit", {9'd0, state}, 12'd1);
    ticks(int'(EXITC) - 1);
    check("t1_exit_hold", {9'd0, state}, 12'd1);
    tick();
    check("t1_armed", {8'd0, state, flag}, {8'd0, 3'd2, 1'b0});
    windowalarm = 1'b1; tick(); windowalarm = 1'b0;
    check("t1_alarm", {5'd0, state, siren, alarm_latched}, {5'd0, 3'd4, 1'b1, 3'b010});

    // Disarm, re-arm, door then disarm inside the entry delay.
    enter(CODE); tick();
    check("t2_disarm", {9'd0, state}, 12'd0);
    enter(CODE); tick(); ticks(int'(EXITC));
    dooralarm = 1'b1; tick(); dooralarm = 1'b0;
    check("t2_entry", {8'd0, state, alarm_latched[0]}, {8'd0, 3'd3, 1'b1});
    enter(CODE); tick();
    check("t2_disarmed", {5'd0, state, flag, siren, alarm_latched},
          {5'd0, 3'd0, 1'b1, 1'b0, 3'b000});

    // Entry timeout, then siren expiry back to ARMED with latch kept.
    enter(CODE); tick(); ticks(int'(EXITC));
    dooralarm = 1'b1; tick(); dooralarm = 1'b0;
    ticks(int'(ENTRYC) - 1);
    check("t3_entry_hold", {9'd0, state}, 12'd3);
    tick();
    check("t3_alarm", {8'd0, state, siren}, {8'd0, 3'd4, 1'b1});
    ticks(int'(SIRENC) - 1);
    check("t3_alarm_hold", {9'd0, state}, 12'd4);
    tick();
    check("t3_rearmed", {5'd0, state, siren, alarm_latched}, {5'd0, 3'd2, 1'b0, 3'b001});

    // Lockout after MAXT wrong codes; keys ignored throughout.
    for (int t = 0; t < MAXT; t++) begin
      enter(16'h9999);
      check1($sformatf("t4_bad%0d", t), code_bad, 1'b1);
      tick();
    end
    check1("t4_lockout", lockout, 1'b1);
    enter(CODE);
    check1("t4_ignored", code_ok, 1'b0);
    tick();
    ticks(int'(LOCKC) - 6);
    check1("t4_lock_hold", lockout, 1'b1);
    tick();
    check1("t4_unlock", lockout, 1'b0);
    enter(CODE);
    check1("t4_accept", code_ok, 1'b1);
    tick();
    check("t4_state", {9'd0, state}, 12'd0);

    // Fire latch survives an accept while fire is still high.
    firealarm = 1'b1; tick();
    check("t5_fire", {8'd0, siren, alarm_latched}, {8'd0, 1'b1, 3'b100});
    enter(CODE); tick();
    check("t5_keep", {6'd0, state, alarm_latched}, {6'd0, 3'd1, 3'b100});
    firealarm = 1'b0; tick();
    enter(CODE); tick();
    check("t5_clear", {5'd0, state, siren, alarm_latched}, {5'd0, 3'd0, 1'b0, 3'b000});

    // Clear key yields one accept; reset from ALARM.
    ok_cnt = 0;
    foreach (tbl[i]) if (i < 0) ok_cnt = 0;
    begin
      logic [3:0] seq [7] = '{4'h1, 4'h2, 4'hC, 4'h1, 4'h2, 4'h3, 4'h4};
      for (int i = 0; i < 7; i++) begin press(seq[i]); ok_cnt += int'(code_ok); end
      for (int i = 0; i < 3; i++) begin tick(); ok_cnt += int'(code_ok); end
    end
    check("t6_one_ok", 12'(ok_cnt), 12'd1);
    ticks(int'(EXITC));
    windowalarm = 1'b1; firealarm = 1'b1; tick(); windowalarm = 1'b0; firealarm = 1'b0;
    check("t6_in_alarm", {9'd0, state}, 12'd4);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6_reset", dut_vec(), {3'd0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0});

    // Random traffic; the model is compared on every tick.
    fire_hold = 0;
    for (int c = 0; c < 30000; c++) begin
      key_valid = 1'b0;
      if (script.size() == 0 && $urandom_range(0, 249) == 0) begin
        int r = int'($urandom_range(0, 99));
        if (r < 55) script = '{4'h1, 4'h2, 4'h3, 4'h4};
        else if (r < 85)
          for (int i = 0; i < 4; i++) script.push_back(4'($urandom_range(0, 9)));
        else script = '{4'h3, 4'hC, 4'h1, 4'h2, 4'h3, 4'h4};
      end
      if (script.size() != 0 && $urandom_range(0, 2) == 0) begin
        key_valid = 1'b1; key = script.pop_front();
      end else if ($urandom_range(0, 59) == 0) begin
        key_valid = 1'b1; key = 4'($urandom);
      end
      dooralarm   = ($urandom_range(0, 59) == 0);
      windowalarm = ($urandom_range(0, 149) == 0);
      if (fire_hold > 0) fire_hold--;
      else if ($urandom_range(0, 499) == 0) fire_hold = int'($urandom_range(1, 20));
      firealarm = (fire_hold > 0);
      reset     = ($urandom_range(0, 3999) == 0);
      tick();
    end
    reset = 1'b0; key_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
